cnn_conv_sequencer: RTL and testbench

CNN_CONV_SEQUENCER -- requirements
Module: cnn_conv_sequencer

---
 rtl/cnn_conv_sequencer.sv | 170 +++++++++++++++++
 tb/tb_cnn_conv_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_sequencer.sv
// Sequencer for a 3x3/4x4 conv core: loads kernel and tile bytes, captures, drains results.
// Define CNN_SEQ_KERNEL_REUSE_EN to let start+keep_kernel skip the kernel load.
module cnn_conv_sequencer #(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             keep_kernel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic [16*DW-1:0] core_inp,
    output logic [9*DW-1:0]  core_ker,
    input  logic [4*DW-1:0]  core_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        LOAD_I,
        COMPUTE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [1:0]      ocnt;
    logic [DW-1:0]   ker [9];
    logic [DW-1:0]   tile [16];
    logic [4*DW-1:0] res;
    logic            kernel_loaded;
    logic            reuse;
    logic            in_fire;
    logic            out_fire;

`ifdef CNN_SEQ_KERNEL_REUSE_EN
    assign reuse = keep_kernel && kernel_loaded;
`else
    logic unused_cfg;
    assign reuse      = 1'b0;
    assign unused_cfg = keep_kernel ^ kernel_loaded;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign busy     = (state != IDLE);

    for (genvar i = 0; i < 9; i++) begin : g_ker
        assign core_ker[i*DW +: DW] = ker[i];
    end

    for (genvar i = 0; i < 16; i++) begin : g_tile
        assign core_inp[i*DW +: DW] = tile[i];
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = reuse ? LOAD_I : LOAD_K;
                end
            end
            LOAD_K: begin
                in_ready = 1'b1;
                if (in_valid && cnt == 4'd8) begin
                    state_nxt = LOAD_I;
                end
            end
            LOAD_I: begin
                in_ready = 1'b1;
                if (in_valid && cnt == 4'd15) begin
                    state_nxt = COMPUTE;
                end
            end
            COMPUTE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && ocnt == 2'd3) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result bytes are only visible while draining so idle outputs read zero.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        if (state == DRAIN) begin
            out_last = (ocnt == 2'd3);
            case (ocnt)
                2'd0:    out_data = res[DW-1:0];
                2'd1:    out_data = res[2*DW-1:DW];
                2'd2:    out_data = res[3*DW-1:2*DW];
                default: out_data = res[4*DW-1:3*DW];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            ocnt          <= '0;
            res           <= '0;
            kernel_loaded <= 1'b0;
            done          <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                ker[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                tile[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    ocnt <= '0;
                end
                LOAD_K: begin
                    if (in_fire) begin
                        ker[cnt] <= in_data;
                        if (cnt == 4'd8) begin
                            cnt           <= '0;
                            kernel_loaded <= 1'b1;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end
                LOAD_I: begin
                    if (in_fire) begin
                        tile[cnt] <= in_data;
                        cnt       <= cnt + 4'd1;
                    end
                end
                COMPUTE: begin
                    res <= core_res;
                end
                DRAIN: begin
                    if (out_fire) begin
                        ocnt <= ocnt + 2'd1;
                        done <= (ocnt == 2'd3);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Scoreboard bench for cnn_conv_sequencer with a behavioural conv reference and core model.
// Honours CNN_SEQ_KERNEL_REUSE_EN when building the reference.
module tb_cnn_conv_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         keep_kernel = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'd0;
    logic [127:0] core_inp;
    logic [71:0]  core_ker;
    logic [31:0]  core_res;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [8:0] sb[$];
    logic [8:0] exp_b;
    bit expect_done = 1'b0;
    bit model_kl = 1'b0;
    int model_ker[3][3];
    logic [7:0] jk[9];
    logic [7:0] jt[16];

`ifdef CNN_SEQ_KERNEL_REUSE_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    cnn_conv_sequencer #(.DW(8)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .keep_kernel(keep_kernel),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .core_inp(core_inp),
        .core_ker(core_ker),
        .core_res(core_res),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Environment model of the convolution core (valid 3x3 correlation, mod 256).
    function automatic logic [31:0] core_fn(input logic [127:0] ti, input logic [71:0] ke);
        int acc;
        core_fn = '0;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                acc = 0;
                for (int kr = 0; kr < 3; kr++) begin
                    for (int kc = 0; kc < 3; kc++) begin
                        acc += int'(ti[((r+kr)*4+c+kc)*8 +: 8]) * int'(ke[(kr*3+kc)*8 +: 8]);
                    end
                end
                core_fn[(r*2+c)*8 +: 8] = acc[7:0];
            end
        end
    endfunction

    assign core_res = core_fn(core_inp, core_ker);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expect_done = 1'b0;
        end else begin
            if (expect_done) begin
                chk("done_pulse", 128'({done, out_valid}), 128'(2'b10));
                expect_done = 1'b0;
                if (done) done_cnt++;
            end else if (done) begin
                chk("spurious_done", 128'(done), 128'(0));
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 128'(out_valid), 128'(0));
                end else if (out_ready) begin
                    exp_b = sb.pop_front();
                    chk("out_byte", 128'({out_last, out_data}), 128'(exp_b));
                    if (exp_b[8]) expect_done = 1'b1;
                end else begin
                    chk("held_byte", 128'({out_last, out_data}), 128'(sb[0]));
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            start    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("in_ready_wait", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_outs"},
            128'({in_ready, out_valid, out_last, out_data, busy, done}), 128'(0));
        chk({tag, "_core_inp"}, core_inp, 128'(0));
        chk({tag, "_core_ker"}, 128'(core_ker), 128'(0));
    endtask

    task automatic hard_reset();
        rst = 1'b1;
        sb.delete();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_kl = 1'b0;
    endtask

    task automatic run_job(input bit keep, input int stall, input int abort_at);
        bit reuse;
        int s, c, d0;
        int t2[4][4];
        reuse = REUSE_EN && keep && model_kl;
        start = 1'b1;
        keep_kernel = keep;
        @(posedge clk); #1;
        start = 1'b0;
        keep_kernel = 1'b0;
        if (!reuse) begin
            for (int i = 0; i < 9; i++) begin
                send(jk[i]);
                model_ker[i/3][i%3] = int'(jk[i]);
            end
            model_kl = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                check_zero_outputs("abort_rst");
                @(posedge clk); #1;
                rst = 1'b0;
                model_kl = 1'b0;
                repeat (3) @(negedge clk);
                chk("abort_idle", 128'({busy, done, out_valid}), 128'(0));
                @(posedge clk); #1;
                return;
            end
            send(jt[i]);
        end
        for (int i = 0; i < 16; i++) t2[i/4][i%4] = int'(jt[i]);
        for (int r = 0; r < 2; r++) begin
            for (int cc = 0; cc < 2; cc++) begin
                s = 0;
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++)
                        s += t2[r+kr][cc+kc] * model_ker[kr][kc];
                sb.push_back({(r == 1 && cc == 1), 8'(s % 256)});
            end
        end
        d0 = done_cnt;
        @(negedge clk);
        chk("compute_cycle", 128'({in_ready, out_valid, busy}), 128'(3'b001));
        @(posedge clk); #1;
        out_ready = (stall > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
        @(negedge clk);
        chk("drain_valid", 128'(out_valid), 128'(1));
        @(posedge clk); #1;
        c = 1;
        while (done_cnt == d0 && c < 100) begin
            out_ready = (c < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b0;
        if (done_cnt == d0) begin
            chk("done_timeout", 128'(done_cnt - d0), 128'(1));
            hard_reset();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 128'({busy, in_ready, out_valid}), 128'(0));

        for (int i = 0; i < 9; i++) jk[i] = 8'd1;
        for (int i = 0; i < 16; i++) jt[i] = 8'd1;
        run_job(1'b0, 0, 16);

        for (int i = 0; i < 9; i++) jk[i] = (i == 4) ? 8'd1 : 8'd0;
        for (int i = 0; i < 16; i++) jt[i] = 8'(i);
        run_job(1'b0, 5, 16);

        for (int i = 0; i < 9; i++) jk[i] = 8'd255;
        for (int i = 0; i < 16; i++) jt[i] = 8'd255;
        run_job(1'b0, 0, 16);

        for (int i = 0; i < 9; i++) jk[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) jt[i] = 8'($urandom_range(0, 255));
        run_job(1'b1, 0, 16);

        for (int i = 0; i < 9; i++) jk[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) jt[i] = 8'($urandom_range(0, 255));
        run_job(1'b0, 0, 7);

        for (int i = 0; i < 9; i++) jk[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) jt[i] = 8'($urandom_range(0, 255));
        run_job(1'b1, 2, 16);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 9; i++) jk[i] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 16; i++) jt[i] = 8'($urandom_range(0, 255));
            run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 16);
        end

        repeat (3) @(negedge clk);
        chk("final_idle", 128'({busy, out_valid, in_ready}), 128'(0));
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
